// File: rtl/led_matrix_pwm.sv
// led_matrix_pwm: row-scanned ROWS x COLS LED matrix driver with per-pixel PWM and a double-buffered frame store.
// Scan counters run one cycle ahead of the registered outputs, so each output register is loaded from the counters' current position.
module led_matrix_pwm #(
  parameter int ROWS         = 4,
  parameter int COLS         = 8,
  parameter int PWM_BITS     = 4,
  parameter int SLOT_CYCLES  = 64,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                      clk12MHz,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [COLS*PWM_BITS-1:0]  wr_data,
  input  logic                      swap_req,
  output logic                      swap_ack,
  output logic                      frame_start,
  output logic [COLS-1:0]           led_n,
  output logic [ROWS-1:0]           lcol_n
);
  localparam int RW    = $clog2(ROWS);
  localparam int DW    = COLS * PWM_BITS;
  localparam int NSLOT = 2**PWM_BITS - 1;
  localparam int CMAX  = BLANK_CYCLES > SLOT_CYCLES ? BLANK_CYCLES : SLOT_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  typedef enum logic {BLANK, PWM} phase_t;

  phase_t                ph_q, ph_d;
  logic [RW-1:0]         row_q, row_d;
  logic [PWM_BITS-1:0]   slot_q, slot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  front_q;
  logic [DW-1:0]         mem_q [2][ROWS];
  logic [DW-1:0]         pix;
  logic                  last_cnt, last_slot, row_end, wr_ok;
  logic [COLS-1:0]       led_d;
  logic [ROWS-1:0]       lcol_d;
  logic                  fs_d, swap_d;

  always_comb begin
    pix       = mem_q[front_q][row_q];
    last_cnt  = ph_q == BLANK ? cnt_q == CW'(BLANK_CYCLES - 1) : cnt_q == CW'(SLOT_CYCLES - 1);
    last_slot = slot_q == PWM_BITS'(NSLOT - 1);
    row_end   = ph_q == PWM && last_cnt && last_slot;
    ph_d      = ph_q == BLANK ? (last_cnt ? PWM : BLANK) : (row_end ? BLANK : PWM);
    cnt_d     = last_cnt ? '0 : cnt_q + 1'b1;
    slot_d    = ph_q == BLANK ? '0 : (last_cnt ? slot_q + 1'b1 : slot_q);
    row_d     = row_end ? (row_q == RW'(ROWS - 1) ? '0 : row_q + 1'b1) : row_q;
    for (int c = 0; c < COLS; c++)
      led_d[c] = !(ph_q == PWM && pix[c*PWM_BITS +: PWM_BITS] > slot_q);
    lcol_d    = ph_q == PWM ? ~(ROWS'(1) << row_q) : '1;
    fs_d      = ph_q == BLANK && row_q == '0 && cnt_q == '0;
    // Only a frame boundary reached from row ROWS-1's PWM phase may swap; the first frame after reset never does.
    swap_d    = fs_d && swap_req && !lcol_n[ROWS-1];
    wr_ok     = wr_en && ({1'b0, wr_row} < (RW+1)'(ROWS));
  end

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      ph_q        <= BLANK;
      row_q       <= '0;
      slot_q      <= '0;
      cnt_q       <= '0;
      front_q     <= 1'b0;
      led_n       <= '1;
      lcol_n      <= '1;
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        mem_q[0][i] <= '0;
        mem_q[1][i] <= '0;
      end
    end else begin
      ph_q        <= ph_d;
      row_q       <= row_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      led_n       <= led_d;
      lcol_n      <= lcol_d;
      frame_start <= fs_d;
      swap_ack    <= swap_d;
      if (swap_d) front_q <= !front_q;
      if (wr_ok) mem_q[!front_q][wr_row] <= wr_data;
    end
  end
endmodule

// File: tb/tb_led_matrix_pwm.sv
// tb_led_matrix_pwm: random and directed stimulus checked every cycle against a frame-position model of the LED scanner.
module tb_led_matrix_pwm;
  localparam int R = 4, C = 8, PB = 2, SC = 2, BC = 1;
  localparam int NS = 2**PB - 1, P = BC + NS*SC, FR = R*P, DW = C*PB;

  logic clk = 0, rst_n = 1, wr_en = 0, swap_req = 0;
  logic [1:0] wr_row = 0;
  logic [DW-1:0] wr_data = 0;
  logic swap_ack, frame_start;
  logic [C-1:0] led_n;
  logic [R-1:0] lcol_n;

  logic wr_en3 = 0, swap_req3 = 0;
  logic [1:0] wr_row3 = 0;
  logic [DW-1:0] wr_data3 = 0;
  logic swap_ack3, fs3;
  logic [C-1:0] led_n3;
  logic [2:0] lcol_n3;

  int pass = 0, total = 0, viol = 0;

  led_matrix_pwm #(.ROWS(R), .COLS(C), .PWM_BITS(PB), .SLOT_CYCLES(SC), .BLANK_CYCLES(BC)) dut (
    .clk12MHz(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_start(frame_start), .led_n(led_n), .lcol_n(lcol_n));

  led_matrix_pwm #(.ROWS(3), .COLS(C), .PWM_BITS(PB), .SLOT_CYCLES(SC), .BLANK_CYCLES(BC)) u3 (
    .clk12MHz(clk), .rst_n(rst_n), .wr_en(wr_en3), .wr_row(wr_row3), .wr_data(wr_data3),
    .swap_req(swap_req3), .swap_ack(swap_ack3), .frame_start(fs3), .led_n(led_n3), .lcol_n(lcol_n3));

  always #5 clk = ~clk;

  task automatic chk(input string n, input longint a, input longint e);
    total++;
    if (a == e) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
  endtask

  // Model: front/back pixel arrays plus the displayed cycle's position k within the frame.
  logic [DW-1:0] mb [2][R];
  int fsel = 0, k = 0;
  bit run = 0, eack = 0, bnd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < R; i++) begin mb[0][i] = '0; mb[1][i] = '0; end
      fsel = 0; k = 0; run = 0; eack = 0;
    end else begin
      if (wr_en) mb[1-fsel][wr_row] = wr_data;
      bnd  = run && k == FR-1;
      eack = bnd && swap_req;
      if (eack) fsel = 1 - fsel;
      k    = run ? (k + 1) % FR : 0;
      run  = 1;
    end
  end

  logic [C-1:0] el;
  logic [R-1:0] ecl;
  logic efs, ea;
  int row, off, s;
  always @(negedge clk) begin
    el = '1; ecl = '1; efs = 0; ea = 0;
    if (rst_n && run) begin
      row = k / P; off = k % P;
      efs = k == 0; ea = eack;
      if (off >= BC) begin
        s = (off - BC) / SC;
        ecl[row] = 1'b0;
        for (int c = 0; c < C; c++) el[c] = !(int'(mb[fsel][row][c*PB +: PB]) > s);
      end
    end
    chk("led_n", led_n, el);
    chk("lcol_n", lcol_n, ecl);
    chk("frame_start", frame_start, efs);
    chk("swap_ack", swap_ack, ea);
    if ($countones(~lcol_n) > 1) viol++;
    if ($countones(~lcol_n3) > 1) viol++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int to, lows, acks, last;
  int lc [4];
  initial begin
    #1 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst led", led_n, 8'hFF);
    chk("rst lcol", lcol_n, 4'hF);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    chk("first fs", frame_start, 1);
    chk("first lcol", lcol_n, 4'hF);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i <= 6) chk("row0 lcol", lcol_n, 4'b1110);
      if (i == 8) chk("row1 lcol", lcol_n, 4'b1101);
    end

    // ROWS=3 instance: out-of-range write is dropped, row index wraps 2->0
    @(posedge clk); #1 wr_en3 = 1; wr_row3 = 2'd3; wr_data3 = '1; swap_req3 = 1;
    @(posedge clk); #1 wr_en3 = 0;
    lows = 0; acks = 0;
    repeat (60) begin
      @(negedge clk);
      if (led_n3 != '1) lows++;
      if (swap_ack3) acks++;
    end
    swap_req3 = 0;
    chk("u3 invalid write lows", lows, 0);
    chk("u3 swaps seen", acks >= 2 ? 1 : 0, 1);
    to = 0;
    do begin @(negedge clk); to++; end while (lcol_n3 != 3'b011 && to < 100);
    to = 0;
    do begin @(negedge clk); to++; end while ((lcol_n3 == 3'b111 || lcol_n3 == 3'b011) && to < 100);
    chk("u3 wrap", lcol_n3, 3'b110);

    repeat (1500) begin
      @(posedge clk); #1;
      wr_en   = ($urandom % 3) == 0;
      wr_row  = 2'($urandom);
      wr_data = 16'($urandom);
      if (swap_ack) swap_req = 0;
      else if ($urandom % 20 == 0) swap_req = 1;
    end
    @(posedge clk); #1 wr_en = 0; swap_req = 0;

    // brightness
    @(posedge clk); #1 wr_en = 1; wr_row = 0; wr_data = 16'h00E4; swap_req = 1;
    @(posedge clk); #1 wr_en = 0;
    to = 0;
    do begin @(negedge clk); to++; end while (!swap_ack && to < 100);
    chk("bright ack seen", to < 100 ? 1 : 0, 1);
    swap_req = 0;
    chk("bright blank led", led_n, 8'hFF);
    for (int c = 0; c < 4; c++) lc[c] = 0;
    repeat (6) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (!led_n[c]) lc[c]++;
    end
    chk("level0 on clocks", lc[0], 0);
    chk("level1 on clocks", lc[1], 2);
    chk("level2 on clocks", lc[2], 4);
    chk("level3 on clocks", lc[3], 6);

    // held request over three frames
    to = 0;
    do begin @(negedge clk); to++; end while (!frame_start && to < 100);
    @(posedge clk); #1 swap_req = 1;
    acks = 0; last = -1;
    for (int i = 1; i <= 84; i++) begin
      @(negedge clk);
      if (swap_ack) begin
        if (last >= 0) chk("ack gap", i - last, 28);
        last = i; acks++;
      end
    end
    swap_req = 0;
    chk("ack count", acks, 3);

    // write in the boundary swap cycle
    to = 0;
    do begin @(negedge clk); to++; end while (!frame_start && to < 100);
    repeat (27) begin @(posedge clk); #1; end
    wr_en = 1; wr_row = 2; wr_data = '1; swap_req = 1;
    @(posedge clk); #1 wr_en = 0; swap_req = 0;
    @(negedge clk);
    chk("collision ack", swap_ack, 1);
    chk("collision fs", frame_start, 1);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i >= 15) chk("row2 full on", led_n, 8'h00);
    end

    // async reset in row 3 PWM
    repeat (4) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("async led", led_n, 8'hFF);
    chk("async lcol", lcol_n, 4'hF);
    chk("async flags", {frame_start, swap_ack}, 2'b00);
    #20;
    @(posedge clk); #1 rst_n = 1; swap_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("restart fs", frame_start, 1);
    chk("restart lcol", lcol_n, 4'hF);
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (led_n != '1) lows++;
    end
    swap_req = 0;
    chk("dark after reset", lows, 0);
    chk("lcol onehot", viol, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
